n64_joybus_controller: RTL and testbench

Behavioural/synthesizable model of a standard N64 game controller on a single open-drain joybus line. It is used as the controller peripheral attached to the PIF replacement's joystick port. It decodes console commands from the line and answers them from static button, stick and accessory inputs using joybus bit timing.

---
 rtl/n64_joybus_controller.sv | 159 +++++++++++++++
 tb/tb_n64_joybus_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_joybus_controller.sv
// N64 controller peripheral on an open-drain joybus line: decodes one console
// command byte and answers info/reset or poll with the standard reply frame.
module n64_joybus_controller #(
    parameter int CLKS_PER_US     = 250,
    parameter int IDLE_TIMEOUT_US = 8
) (
    input  logic       clock,
    input  logic       reset_l,
    input  logic       A,
    input  logic       B,
    input  logic       Z,
    input  logic       START,
    input  logic       gray_UP,
    input  logic       gray_DOWN,
    input  logic       gray_LEFT,
    input  logic       gray_RIGHT,
    input  logic       L,
    input  logic       R,
    input  logic       yellow_UP,
    input  logic       yellow_DOWN,
    input  logic       yellow_LEFT,
    input  logic       yellow_RIGHT,
    input  logic [7:0] joystick_X,
    input  logic [7:0] joystick_Y,
    input  logic       mem_rumble,
    inout  wire        out
);

    localparam int CW = $clog2((IDLE_TIMEOUT_US + 4) * CLKS_PER_US + 1);
    localparam logic [CW-1:0] T1   = CW'(CLKS_PER_US);
    localparam logic [CW-1:0] T2   = CW'(2 * CLKS_PER_US);
    localparam logic [CW-1:0] T3   = CW'(3 * CLKS_PER_US);
    localparam logic [CW-1:0] TBIT = CW'(4 * CLKS_PER_US);
    localparam logic [CW-1:0] TTO  = CW'(IDLE_TIMEOUT_US * CLKS_PER_US);

    typedef enum logic [2:0] {
        IDLE, RX_CMD, RX_STOP, TURNAROUND, TX, TX_STOP
    } state_t;

    state_t         state_q;
    logic [1:0]     sync_q;
    logic           line_prev_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     bit_cnt_q;
    logic [5:0]     bits_left_q;
    logic [7:0]     cmd_q;
    logic [31:0]    reply_q;
    logic           drive_q;
    logic [31:0]    reply_d;
    logic [5:0]     nbits_d;

    logic line_s, fall, rise;
    assign line_s = sync_q[1];
    assign fall   = line_prev_q & ~line_s;
    assign rise   = ~line_prev_q & line_s;

    assign out = drive_q ? 1'b0 : 1'bz;

    // Reply frame left-aligned in 32 bits; nbits_d == 0 means the command gets no answer.
    always_comb begin
        reply_d = '0;
        nbits_d = '0;
        case (cmd_q)
            8'h00, 8'hFF: begin
                reply_d = {8'h05, 8'h00, (mem_rumble ? 8'h01 : 8'h02), 8'h00};
                nbits_d = 6'd24;
            end
            8'h01: begin
                reply_d = {A, B, Z, START, gray_UP, gray_DOWN, gray_LEFT, gray_RIGHT,
                           2'b00, L, R, yellow_UP, yellow_DOWN, yellow_LEFT, yellow_RIGHT,
                           joystick_X, joystick_Y};
                nbits_d = 6'd32;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            line_prev_q <= 1'b1;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            bits_left_q <= '0;
            cmd_q       <= '0;
            reply_q     <= '0;
            drive_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], out};
            line_prev_q <= line_s;
            case (state_q)
                IDLE: begin
                    drive_q <= 1'b0;
                    if (fall) begin
                        state_q   <= RX_CMD;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                RX_CMD, RX_STOP: begin
                    // cnt_q measures time since the last edge, saturating at the abort limit.
                    if (fall || rise)
                        cnt_q <= '0;
                    else if (cnt_q != TTO)
                        cnt_q <= cnt_q + 1'b1;
                    if (rise && state_q == RX_CMD) begin
                        cmd_q <= {cmd_q[6:0], (cnt_q < T2)};
                        if (bit_cnt_q == 3'd7)
                            state_q <= RX_STOP;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end else if (rise) begin
                        reply_q     <= reply_d;
                        bits_left_q <= nbits_d;
                        state_q     <= (nbits_d == '0) ? IDLE : TURNAROUND;
                    end else if (line_s && cnt_q >= TTO) begin
                        state_q <= IDLE;
                    end
                end
                TURNAROUND: begin
                    if (cnt_q == T2 - 1'b1) begin
                        cnt_q   <= '0;
                        drive_q <= 1'b1;
                        state_q <= TX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                TX: begin
                    // drive_q tracks (cnt_q < low time of the current bit).
                    if (cnt_q == TBIT - 1'b1) begin
                        cnt_q   <= '0;
                        drive_q <= 1'b1;
                        if (bits_left_q == 6'd1) begin
                            state_q <= TX_STOP;
                        end else begin
                            reply_q     <= {reply_q[30:0], 1'b0};
                            bits_left_q <= bits_left_q - 1'b1;
                        end
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        drive_q <= (cnt_q + 1'b1) < (reply_q[31] ? T1 : T3);
                    end
                end
                TX_STOP: begin
                    if (cnt_q == T2 - 1'b1) begin
                        cnt_q   <= '0;
                        drive_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_n64_joybus_controller.sv
// Bench for n64_joybus_controller: console-side command driver plus a line
// monitor that decodes reply bits and checks them against a byte scoreboard.
module tb_n64_joybus_controller;

    localparam int C   = 20;
    localparam int BIT = 4 * C;

    logic clock   = 1'b0;
    logic reset_l = 1'b0;
    logic [7:0] btn0 = '0;
    logic [5:0] btn1 = '0;
    logic [7:0] jx = '0;
    logic [7:0] jy = '0;
    logic mem = 1'b0;
    logic console_low = 1'b0;
    logic console_tx  = 1'b0;

    logic A, B, Z, START, gU, gD, gL, gR, L, R, yU, yD, yL, yR;
    assign {A, B, Z, START, gU, gD, gL, gR} = btn0;
    assign {L, R, yU, yD, yL, yR} = btn1;

    wire joy_line;
    pullup (joy_line);
    assign joy_line = console_low ? 1'b0 : 1'bz;

    always #2 clock = ~clock;

    n64_joybus_controller #(.CLKS_PER_US(C), .IDLE_TIMEOUT_US(8)) dut (
        .clock(clock), .reset_l(reset_l),
        .A(A), .B(B), .Z(Z), .START(START),
        .gray_UP(gU), .gray_DOWN(gD), .gray_LEFT(gL), .gray_RIGHT(gR),
        .L(L), .R(R),
        .yellow_UP(yU), .yellow_DOWN(yD), .yellow_LEFT(yL), .yellow_RIGHT(yR),
        .joystick_X(jx), .joystick_Y(jy), .mem_rumble(mem), .out(joy_line)
    );

    int checks = 0;
    int passed = 0;
    int frames_seen = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                      name, actual, actual, expected, expected);
    endtask

    task automatic check_tol(input string name, input int actual, input int expected, input int tol);
        checks++;
        if (actual >= expected - tol && actual <= expected + tol) passed++;
        else $display("FAIL %s: got %0d, expected %0d +/- %0d", name, actual, expected, tol);
    endtask

    // Reply decoder: ignores the line while the console is transmitting.
    initial begin : monitor
        int lowlen;
        int last_fall;
        int nbits;
        logic [7:0] sh;
        last_fall = -100000;
        nbits = 0;
        sh = '0;
        forever begin
            @(negedge clock);
            if (console_tx || joy_line !== 1'b0) continue;
            if (cyc - last_fall > 2 * BIT) nbits = 0;
            else if (nbits > 0) check_tol("bit_period", cyc - last_fall, BIT, 1);
            last_fall = cyc;
            lowlen = 0;
            while (joy_line === 1'b0 && lowlen <= 4 * C) begin
                @(negedge clock);
                lowlen++;
            end
            if (lowlen > 3 * C / 2 && lowlen < 5 * C / 2) begin
                check("stop_byte_aligned", nbits % 8, 0);
                check_tol("stop_low_time", lowlen, 2 * C, 1);
                frames_seen++;
                nbits = 0;
            end else begin
                check_tol("bit_low_time", lowlen, (lowlen < 2 * C) ? C : 3 * C, 1);
                sh = {sh[6:0], (lowlen < 2 * C)};
                nbits++;
                if (nbits % 8 == 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_byte: got 0x%02h, expected no byte", sh);
                    end else begin
                        check("reply_byte", sh, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clock);
        console_low = 1'b1;
        repeat (b ? C : 3 * C) @(negedge clock);
        console_low = 1'b0;
        repeat (b ? 3 * C - 1 : C - 1) @(negedge clock);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        console_tx = 1'b1;
        for (int i = 7; i >= 0; i--) send_bit(c[i]);
        @(negedge clock);
        console_low = 1'b1;
        repeat (C) @(negedge clock);
        console_low = 1'b0;
        console_tx = 1'b0;
    endtask

    task automatic expect_reply(input logic [31:0] r, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(r[31 - 8 * i -: 8]);
    endtask

    task automatic wait_frame(input int target, input string name);
        int n;
        n = 0;
        while (frames_seen < target && n < 50 * BIT) begin
            @(negedge clock);
            n++;
        end
        check(name, frames_seen, target);
        check({name, "_all_bytes"}, exp_q.size(), 0);
        repeat (2 * C) @(negedge clock);
    endtask

    task automatic expect_quiet(input int cycles, input string name);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (joy_line !== 1'b1) lows++;
        end
        check(name, lows, 0);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  b0;
        logic [5:0]  b1;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        mem;
        int          n;
        logic [31:0] reply;
    } vec_t;

    vec_t vecs[6];
    int target;

    task automatic apply(input vec_t v);
        btn0 = v.b0; btn1 = v.b1; jx = v.x; jy = v.y; mem = v.mem;
    endtask

    initial begin
        vecs[0] = '{8'h01, 8'h10, 6'b110000, 8'h05, 8'h04, 1'b0, 4, 32'h1030_0504};
        vecs[1] = '{8'h00, 8'h00, 6'b000000, 8'h00, 8'h00, 1'b0, 3, 32'h0500_0200};
        vecs[2] = '{8'h00, 8'h00, 6'b000000, 8'h00, 8'h00, 1'b1, 3, 32'h0500_0100};
        vecs[3] = '{8'hFF, 8'h00, 6'b000000, 8'h00, 8'h00, 1'b0, 3, 32'h0500_0200};
        vecs[4] = '{8'h01, 8'hA5, 6'b001111, 8'h80, 8'h7F, 1'b1, 4, 32'hA50F_807F};
        vecs[5] = '{8'hFF, 8'h3C, 6'b101010, 8'h11, 8'h22, 1'b1, 3, 32'h0500_0100};
        target = 0;

        repeat (5) @(negedge clock);
        check("reset_line_released", int'(joy_line), 1);
        reset_l = 1'b1;
        expect_quiet(4 * C, "idle_line_released");

        for (int i = 0; i < 6; i++) begin
            apply(vecs[i]);
            expect_reply(vecs[i].reply, vecs[i].n);
            send_cmd(vecs[i].cmd);
            target++;
            wait_frame(target, "vec_frame");
            $display("txn vec%0d cmd=%02h reply_bytes=%0d frames=%0d", i, vecs[i].cmd, vecs[i].n, frames_seen);
        end

        // Unsupported command: silence, then a poll still works.
        send_cmd(8'h02);
        expect_quiet(50 * C, "unsupported_quiet");
        check("unsupported_no_frame", frames_seen, target);
        $display("txn unsupported cmd=02 frames=%0d", frames_seen);
        apply(vecs[0]);
        expect_reply(vecs[0].reply, 4);
        send_cmd(8'h01);
        target++;
        wait_frame(target, "poll_after_unsupported");
        $display("txn poll after unsupported frames=%0d", frames_seen);

        // Truncated command: 3 bits then long high time aborts reception.
        console_tx = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        console_tx = 1'b0;
        expect_quiet(10 * C, "truncated_quiet");
        check("truncated_no_frame", frames_seen, target);
        $display("txn truncated 3 bits frames=%0d", frames_seen);
        apply(vecs[1]);
        expect_reply(vecs[1].reply, 3);
        send_cmd(8'h00);
        target++;
        wait_frame(target, "info_after_truncated");
        $display("txn info after truncated frames=%0d", frames_seen);

        // Reset in the high phase of reply bit 10.
        apply(vecs[0]);
        expect_reply(vecs[0].reply, 4);
        send_cmd(8'h01);
        repeat (2 * C + 10 * BIT + 3 * C + C / 2) @(negedge clock);
        reset_l = 1'b0;
        expect_quiet(2 * C, "reset_mid_tx_released");
        reset_l = 1'b1;
        exp_q.delete();
        expect_quiet(3 * BIT, "after_reset_quiet");
        check("reset_aborted_frame", frames_seen, target);
        $display("txn reset mid-tx frames=%0d", frames_seen);
        expect_reply(vecs[0].reply, 4);
        send_cmd(8'h01);
        target++;
        wait_frame(target, "poll_after_reset");
        $display("txn poll after reset frames=%0d", frames_seen);

        // Input changes during byte0 must not disturb the frame in flight.
        apply(vecs[0]);
        expect_reply(32'h1030_0504, 4);
        send_cmd(8'h01);
        repeat (2 * C + 4 * BIT) @(negedge clock);
        btn0[7] = 1'b1;
        jx = 8'hF0;
        target++;
        wait_frame(target, "snapshot_frame");
        $display("txn snapshot poll frames=%0d", frames_seen);
        expect_reply(32'h9030_F004, 4);
        send_cmd(8'h01);
        target++;
        wait_frame(target, "poll_after_snapshot");
        $display("txn poll after snapshot frames=%0d", frames_seen);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
